// File: rtl/uart_line_editor.sv
// Line editor: assembles rx bytes into an edit line, commits on CR to a display buffer, echoes via FIFO to the TX.
// One rx byte is skidded while busy (a second is lost, sets overflow); echo pushes into a full FIFO are dropped (sets overflow).
module uart_line_editor #(
  parameter int                   DATA_BITS = 8,
  parameter int                   LINE_LEN  = 16,
  parameter int                   FIFO_EXP  = 4,
  parameter logic [DATA_BITS-1:0] PAD_CHAR  = DATA_BITS'(8'h20)
) (
  input  logic                            clk_50MHz,
  input  logic                            reset,
  input  logic                            rx_valid,
  input  logic [DATA_BITS-1:0]            rx_data,
  input  logic [1:0]                      echo_mode,
  input  logic                            tx_busy,
  output logic                            tx_start,
  output logic [DATA_BITS-1:0]            tx_data,
  input  logic [$clog2(LINE_LEN)-1:0]     rd_addr,
  output logic [DATA_BITS-1:0]            rd_char,
  output logic                            line_ready,
  output logic [$clog2(LINE_LEN+1)-1:0]   line_len,
  output logic                            fifo_full,
  output logic                            fifo_empty,
  output logic                            overflow
);

  localparam int AW    = $clog2(LINE_LEN);
  localparam int LW    = $clog2(LINE_LEN + 1);
  localparam int DEPTH = 1 << FIFO_EXP;

  localparam logic [DATA_BITS-1:0] C_BS   = DATA_BITS'(8'h08);
  localparam logic [DATA_BITS-1:0] C_DEL  = DATA_BITS'(8'h7F);
  localparam logic [DATA_BITS-1:0] C_CR   = DATA_BITS'(8'h0D);
  localparam logic [DATA_BITS-1:0] C_LF   = DATA_BITS'(8'h0A);
  localparam logic [DATA_BITS-1:0] C_SP   = DATA_BITS'(8'h20);
  localparam logic [DATA_BITS-1:0] C_TIL  = DATA_BITS'(8'h7E);
  localparam logic [DATA_BITS-1:0] C_LA   = DATA_BITS'(8'h61);
  localparam logic [DATA_BITS-1:0] C_LZ   = DATA_BITS'(8'h7A);

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_COPY} state_t;
  typedef enum logic {T_IDLE, T_WAIT} tx_state_t;

  state_t                 r_state, w_state_nx;
  tx_state_t              r_tx_state, w_tx_nx;
  logic [DATA_BITS-1:0]   r_byte;
  logic                   r_pend_v;
  logic [DATA_BITS-1:0]   r_pend_dat;
  logic [LW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_copy_idx;
  logic [1:0]             r_bs_step;
  logic                   r_lf_pend;
  logic [LW-1:0]          r_line_len;
  logic                   r_line_ready;
  logic                   r_overflow;
  logic [DATA_BITS-1:0]   r_rd_char;
  logic [DATA_BITS-1:0]   r_edit [LINE_LEN];
  logic [DATA_BITS-1:0]   r_disp [LINE_LEN];

  logic [DATA_BITS-1:0]   r_mem [DEPTH];
  logic [FIFO_EXP-1:0]    r_head, r_tail;
  logic [FIFO_EXP:0]      r_count;

  logic                   w_push, w_push_ok, w_pop;
  logic [DATA_BITS-1:0]   w_push_dat;
  logic                   w_fifo_full, w_fifo_empty;
  logic                   w_echo_on;
  logic [DATA_BITS-1:0]   w_echo_byte;
  logic                   w_is_print, w_is_bs, w_is_cr, w_is_lf;
  logic [LW-1:0]          w_wr_dec;
  logic                   w_copy_last;

  assign w_echo_on   = (echo_mode == 2'b01) || (echo_mode == 2'b10);
  assign w_echo_byte = (echo_mode == 2'b10 && r_byte >= C_LA && r_byte <= C_LZ) ? (r_byte - C_SP) : r_byte;
  assign w_is_print  = (r_byte >= C_SP) && (r_byte <= C_TIL);
  assign w_is_bs     = (r_byte == C_BS) || (r_byte == C_DEL);
  assign w_is_cr     = (r_byte == C_CR);
  assign w_is_lf     = (r_byte == C_LF);
  assign w_wr_dec    = r_wr_ptr - 1'b1;
  assign w_copy_last = (r_copy_idx == AW'(LINE_LEN - 1));

  assign w_fifo_full  = (r_count == (FIFO_EXP+1)'(DEPTH));
  assign w_fifo_empty = (r_count == '0);
  assign w_push_ok    = w_push && (!w_fifo_full || w_pop);

  always_comb begin
    w_state_nx = r_state;
    w_push     = 1'b0;
    w_push_dat = '0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_v || rx_valid) w_state_nx = S_PROC;
      end
      S_PROC: begin
        if (w_is_cr) begin
          w_push     = w_echo_on;
          w_push_dat = C_CR;
          w_state_nx = S_COPY;
        end else if (w_is_bs) begin
          w_state_nx = S_IDLE;
          if (w_echo_on) begin
            // Erase sequence BS, SP, BS takes one PROC cycle per character
            w_push     = 1'b1;
            w_push_dat = (r_bs_step == 2'd1) ? C_SP : C_BS;
            if (r_bs_step != 2'd2) w_state_nx = S_PROC;
          end
        end else if (w_is_lf) begin
          w_state_nx = S_IDLE;
        end else begin
          w_push     = w_echo_on;
          w_push_dat = w_echo_byte;
          w_state_nx = S_IDLE;
        end
      end
      S_COPY: begin
        w_push     = r_lf_pend;
        w_push_dat = C_LF;
        if (w_copy_last) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_byte       <= '0;
      r_pend_v     <= 1'b0;
      r_pend_dat   <= '0;
      r_wr_ptr     <= '0;
      r_copy_idx   <= '0;
      r_bs_step    <= 2'd0;
      r_lf_pend    <= 1'b0;
      r_line_len   <= '0;
      r_line_ready <= 1'b0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < LINE_LEN; i++) begin
        r_edit[i] <= PAD_CHAR;
        r_disp[i] <= PAD_CHAR;
      end
    end else begin
      r_state      <= w_state_nx;
      r_line_ready <= 1'b0;
      if (w_push && !w_push_ok) r_overflow <= 1'b1;

      if (r_state == S_IDLE) begin
        if (r_pend_v) begin
          r_byte   <= r_pend_dat;
          r_pend_v <= rx_valid;
          if (rx_valid) r_pend_dat <= rx_data;
        end else if (rx_valid) begin
          r_byte <= rx_data;
        end
      end else if (rx_valid) begin
        if (r_pend_v) begin
          r_overflow <= 1'b1;
        end else begin
          r_pend_v   <= 1'b1;
          r_pend_dat <= rx_data;
        end
      end

      r_bs_step <= (r_state == S_PROC && w_state_nx == S_PROC) ? r_bs_step + 2'd1 : 2'd0;

      // Line edits happen once per byte, on the first PROC cycle only
      if (r_state == S_PROC && r_bs_step == 2'd0) begin
        if (w_is_print) begin
          if (r_wr_ptr < LW'(LINE_LEN)) begin
            r_edit[r_wr_ptr[AW-1:0]] <= r_byte;
            r_wr_ptr                 <= r_wr_ptr + 1'b1;
          end
        end else if (w_is_bs) begin
          if (r_wr_ptr != '0) begin
            r_edit[w_wr_dec[AW-1:0]] <= PAD_CHAR;
            r_wr_ptr                 <= w_wr_dec;
          end
        end else if (w_is_cr) begin
          r_lf_pend  <= w_echo_on;
          r_copy_idx <= '0;
        end
      end

      if (r_state == S_COPY) begin
        r_disp[r_copy_idx] <= r_edit[r_copy_idx];
        r_edit[r_copy_idx] <= PAD_CHAR;
        r_lf_pend          <= 1'b0;
        r_copy_idx         <= r_copy_idx + 1'b1;
        if (w_copy_last) begin
          r_line_len   <= r_wr_ptr;
          r_wr_ptr     <= '0;
          r_line_ready <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) r_rd_char <= '0;
    else       r_rd_char <= (int'(rd_addr) < LINE_LEN) ? r_disp[rd_addr] : PAD_CHAR;
  end

  always_ff @(posedge clk_50MHz) begin
    if (w_push_ok) r_mem[r_tail] <= w_push_dat;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      if (w_pop)     r_head <= r_head + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_tx_nx = r_tx_state;
    w_pop   = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (!w_fifo_empty && !tx_busy) begin
          w_pop   = 1'b1;
          w_tx_nx = T_WAIT;
        end
      end
      T_WAIT: begin
        if (tx_busy) w_tx_nx = T_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) r_tx_state <= T_IDLE;
    else       r_tx_state <= w_tx_nx;
  end

  assign tx_start   = w_pop;
  assign tx_data    = w_pop ? r_mem[r_head] : '0;
  assign rd_char    = r_rd_char;
  assign line_ready = r_line_ready;
  assign line_len   = r_line_len;
  assign fifo_full  = w_fifo_full;
  assign fifo_empty = w_fifo_empty;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_line_editor.sv
// Directed bench for uart_line_editor: expected echo bytes are queued by stimulus and popped by a tx monitor.
module tb_uart_line_editor;
  localparam int LINE_LEN = 16;

  logic       clk_50MHz = 1'b0;
  logic       reset     = 1'b1;
  logic       rx_valid  = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic [1:0] echo_mode = 2'b00;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] rd_addr   = 4'd0;
  logic [7:0] rd_char;
  logic       line_ready;
  logic [4:0] line_len;
  logic       fifo_full, fifo_empty, overflow;

  logic       hold_busy = 1'b0;
  int         busy_cnt  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         tx_cnt  = 0;
  int         lr_cnt  = 0;
  int         lr0, tx0;

  uart_line_editor dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .echo_mode (echo_mode),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .line_ready(line_ready),
    .line_len  (line_len),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .overflow  (overflow)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Transmitter model: busy for 4 cycles after each start
  assign tx_busy = hold_busy || (busy_cnt != 0);
  always @(posedge clk_50MHz) begin
    if (tx_start)          busy_cnt <= 4;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk_50MHz) begin
    if (line_ready) lr_cnt++;
    if (tx_start) begin
      tx_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got %02h, required no transmission", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_byte: got %02h, required %02h", tx_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk_50MHz);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_50MHz);
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    strobe(b);
    repeat (6) @(negedge clk_50MHz);
    if (b == 8'h0D) repeat (LINE_LEN + 4) @(negedge clk_50MHz);
  endtask

  task automatic chk_disp(input int a, input logic [7:0] e);
    @(negedge clk_50MHz);
    rd_addr = 4'(a);
    @(negedge clk_50MHz);
    check($sformatf("disp[%0d]", a), rd_char, e);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 600) begin
      @(negedge clk_50MHz);
      i++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (8) @(negedge clk_50MHz);
    check("fifo_empty_after_drain", fifo_empty, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_tx_start"},   tx_start,   0);
    check({tag, "_tx_data"},    tx_data,    0);
    check({tag, "_line_ready"}, line_ready, 0);
    check({tag, "_line_len"},   line_len,   0);
    check({tag, "_fifo_full"},  fifo_full,  0);
    check({tag, "_fifo_empty"}, fifo_empty, 1);
    check({tag, "_overflow"},   overflow,   0);
    check({tag, "_rd_char"},    rd_char,    0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_50MHz);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk_50MHz);
    chk_reset_outputs(tag);
    reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_50MHz);
    chk_reset_outputs("reset");
    reset = 1'b0;
    chk_disp(0, 8'h20);

    // Raw echo, "HI" CR
    echo_mode = 2'b01;
    lr0 = lr_cnt;
    exp_q.push_back(8'h48); exp_q.push_back(8'h49);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h48); send(8'h49); send(8'h0D);
    check("t1_line_len", line_len, 2);
    check("t1_line_ready", lr_cnt - lr0, 1);
    chk_disp(0, 8'h48);
    chk_disp(1, 8'h49);
    for (int i = 2; i < LINE_LEN; i++) chk_disp(i, 8'h20);
    wait_drain();

    // Uppercase echo with backspace: display keeps raw bytes
    echo_mode = 2'b10;
    lr0 = lr_cnt;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    exp_q.push_back(8'h08); exp_q.push_back(8'h20); exp_q.push_back(8'h08);
    exp_q.push_back(8'h43); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h61); send(8'h62); send(8'h08); send(8'h63); send(8'h0D);
    check("t2_line_len", line_len, 2);
    check("t2_line_ready", lr_cnt - lr0, 1);
    chk_disp(0, 8'h61);
    chk_disp(1, 8'h63);
    chk_disp(2, 8'h20);
    wait_drain();

    // 20 printable bytes, echo off: only the first 16 land in the line
    echo_mode = 2'b00;
    for (int i = 0; i < 20; i++) send(8'h41 + 8'(i));
    send(8'h0D);
    check("t3_line_len", line_len, 16);
    check("t3_overflow", overflow, 0);
    for (int i = 0; i < LINE_LEN; i++) chk_disp(i, 8'h41 + 8'(i));

    // Empty commit, then two bytes arriving during COPY
    lr0 = lr_cnt;
    strobe(8'h0D);
    repeat (2) @(negedge clk_50MHz);
    strobe(8'h50);
    strobe(8'h51);
    repeat (LINE_LEN + 10) @(negedge clk_50MHz);
    check("t5_empty_line_len", line_len, 0);
    check("t5_line_ready", lr_cnt - lr0, 1);
    check("t5_overflow", overflow, 1);
    chk_disp(0, 8'h20);
    chk_disp(15, 8'h20);
    send(8'h0D);
    check("t5_pending_len", line_len, 1);
    chk_disp(0, 8'h50);
    chk_disp(1, 8'h20);
    // Backspace at column 0 is a no-op
    send(8'h08); send(8'h5A); send(8'h0D);
    check("t5_bs0_len", line_len, 1);
    chk_disp(0, 8'h5A);
    chk_disp(1, 8'h20);

    // FIFO fill with the transmitter held busy
    do_reset("reset2");
    echo_mode = 2'b01;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
    for (int i = 0; i < 17; i++) send(8'h80 + 8'(i));
    check("t4_fifo_full", fifo_full, 1);
    check("t4_overflow", overflow, 1);
    tx0 = tx_cnt;
    hold_busy = 1'b0;
    wait_drain();
    check("t4_tx_count", tx_cnt - tx0, 16);

    // Reset asserted in the middle of COPY
    echo_mode = 2'b00;
    send(8'h41); send(8'h42);
    strobe(8'h0D);
    repeat (5) @(negedge clk_50MHz);
    reset = 1'b1;
    @(negedge clk_50MHz);
    chk_reset_outputs("reset_copy");
    reset = 1'b0;
    for (int i = 0; i < LINE_LEN; i++) chk_disp(i, 8'h20);
    check("t6_line_len", line_len, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_line_editor.md
Name: uart_line_editor

Overview:
Byte-level line editor and echo engine between the UART receiver and transmitter and the LCD1602 controller. It accepts received bytes and assembles printable characters into an edit line, with backspace support. On CR it commits the line to a display buffer that the LCD controller reads by address. Received bytes are echoed through an internal FIFO to the UART transmitter in a selectable mode (off / raw / uppercase).

Parameters:
DATA_BITS, 8, character width
LINE_LEN, 16, characters per line (2..64)
FIFO_EXP, 4, echo FIFO depth = 2**FIFO_EXP
PAD_CHAR, 8'h20, fill character for empty positions

Ports:
clk_50MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  DATA_BITS  received byte
echo_mode  in  2  00/11 off, 01 raw, 10 uppercase
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  DATA_BITS  byte to send, valid while tx_start=1
rd_addr  in  $clog2(LINE_LEN)  display buffer read address
rd_char  out  DATA_BITS  display character, registered
line_ready  out  1  one-cycle pulse when a commit completes
line_len  out  $clog2(LINE_LEN+1)  length of last committed line
fifo_full  out  1  echo FIFO full
fifo_empty  out  1  echo FIFO empty
overflow  out  1  sticky: byte or echo lost

Behaviour:
- Reset: all outputs 0 except fifo_empty=1. Edit and display buffers all PAD_CHAR. wr_ptr=0. FSM in IDLE. Reset mid-COPY aborts the copy; the display buffer returns to all PAD_CHAR.
- FSM states:
  - IDLE: waits for a byte. If pend_v=1, the pending byte is processed first (PROC, no new rx needed). Otherwise rx_valid -> latch byte, go to PROC.
  - PROC: one cycle. Classify the byte, then go to IDLE, or to COPY on CR.
  - COPY: LINE_LEN cycles. Each cycle i: disp[i]<=edit[i] and edit[i]<=PAD_CHAR. After the last index: line_len<=wr_ptr, wr_ptr<=0, line_ready pulses, go to IDLE.
- Byte rules in PROC:
  - 0x20..0x7E: if wr_ptr<LINE_LEN, edit[wr_ptr]<=byte and wr_ptr++. Otherwise the byte is dropped from the line but still echoed. overflow is not set for this case.
  - 0x08 or 0x7F: if wr_ptr>0, wr_ptr-- and edit[wr_ptr-1]<=PAD_CHAR. At wr_ptr=0 it is a no-op.
  - 0x0D: commit (go to COPY). An empty line (wr_ptr=0) is still committed: display becomes all PAD_CHAR, line_len=0.
  - 0x0A: ignored, not echoed.
  - Any other byte: ignored, echoed raw.
- Skid register:
  - rx_valid while not in IDLE stores the byte into a 1-entry pending register (pend_v).
  - rx_valid while pend_v=1 and not in IDLE: byte lost, overflow<=1.
  - rx_valid in IDLE with pend_v=1: pending byte is processed, the new byte goes into pending.
- Echo (mode 01 or 10), pushed in PROC:
  - Pushes the byte; mode 10 maps 0x61..0x7A to minus 0x20.
  - CR pushes 0x0D then 0x0A; the second push happens in the first COPY cycle.
  - Backspace pushes 0x08, 0x20, 0x08 (PROC, COPY-free extra cycles: the FSM stays in PROC until all three are pushed).
  - A push while full is dropped and sets overflow<=1.
- FIFO: circular, 2**FIFO_EXP entries. Pointers wrap modulo depth. Simultaneous push and pop is allowed when full (pop frees the slot, push succeeds) and when empty (push only).
- TX handshake:
  - TX FSM T_IDLE -> T_WAIT. In T_IDLE, if !fifo_empty && !tx_busy: tx_start=1, tx_data=head, pop, go to T_WAIT.
  - In T_WAIT, return to T_IDLE on the first cycle tx_busy=1.
  - Guarantees exactly one start per byte.
- rd_char <= disp[rd_addr] every cycle (1-cycle latency). rd_addr>=LINE_LEN returns PAD_CHAR.
- overflow clears only on reset.

Test Plan:
- Mode 01: send "HI",0x0D → disp[0..1]="HI", disp[2..15]=0x20, line_len=2, one line_ready pulse; tx sequence 0x48,0x49,0x0D,0x0A.
- Mode 10: send "ab",0x08,"c",0x0D → display "aC"? No: display stores raw bytes, so display is "ac", line_len=2; tx sequence 0x41,0x42,0x08,0x20,0x08,0x43,0x0D,0x0A.
- Send 20 printable bytes then 0x0D with LINE_LEN=16 → first 16 displayed, line_len=16, overflow=0.
- Mode 01, tx_busy held 1, push 17 bytes with FIFO_EXP=4 → fifo_full=1, overflow=1. Release tx_busy → exactly 16 bytes transmitted, fifo_empty=1.
- 0x0D followed by two rx_valid strobes during COPY: first byte processed after COPY, second lost with overflow=1. Third case: 0x08 at wr_ptr=0 → no change.
- Assert reset during COPY → all outputs at reset values, rd_char=0x20 for every address one cycle after.
